// File: rtl/axi_lite_reg_responder.sv
// AXI4-Lite responder backed by a bank of NumRegs registers.
// AW and W are buffered in independent one-deep slots and committed together.
// Hardware may load any register directly, and that load takes priority over a bus write.

package axi_lite_reg_responder_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  prot;
  } ax_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
  } w_chan_t;

  typedef struct packed {
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    w_ready;
    b_chan_t b;
    logic    b_valid;
    logic    ar_ready;
    r_chan_t r;
    logic    r_valid;
  } rsp_t;
endpackage

module axi_lite_reg_responder #(
  parameter int unsigned                  AddrWidth = 32,
  parameter int unsigned                  DataWidth = 32,
  parameter int unsigned                  NumRegs   = 16,
  parameter logic [AddrWidth-1:0]         BaseAddr  = '0,
  parameter logic [NumRegs-1:0]           RoMask    = '0,
  parameter logic [NumRegs*DataWidth-1:0] RegRstVal = '0,
  parameter type axi_lite_req_t = axi_lite_reg_responder_pkg::req_t,
  parameter type axi_lite_rsp_t = axi_lite_reg_responder_pkg::rsp_t
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  axi_lite_req_t                  slv_req_i,
  output axi_lite_rsp_t                  slv_resp_o,
  output logic [NumRegs*DataWidth-1:0]   reg_q_o,
  input  logic [NumRegs-1:0]             reg_load_i,
  input  logic [NumRegs*DataWidth-1:0]   reg_d_i
);
  localparam int unsigned StrbWidth  = DataWidth / 8;
  localparam int unsigned OffBits    = $clog2(StrbWidth);
  localparam int unsigned IdxBits    = (NumRegs > 1) ? $clog2(NumRegs) : 1;
  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespSlvErr = 2'b10;

  function automatic logic addr_hit(input logic [AddrWidth-1:0] addr);
    logic [AddrWidth-1:0] word;
    word = (addr - BaseAddr) >> OffBits;
    return (addr >= BaseAddr) && (word < AddrWidth'(NumRegs));
  endfunction

  function automatic logic [IdxBits-1:0] addr_idx(input logic [AddrWidth-1:0] addr);
    return IdxBits'((addr - BaseAddr) >> OffBits);
  endfunction

  logic                              aw_full_q, w_full_q, b_valid_q, r_valid_q;
  logic [AddrWidth-1:0]              aw_addr_q;
  logic [DataWidth-1:0]              w_data_q, r_data_q;
  logic [StrbWidth-1:0]              w_strb_q;
  logic [1:0]                        b_resp_q, r_resp_q;
  logic [NumRegs-1:0][DataWidth-1:0] regs_q, regs_d;
  logic                              aw_hs, w_hs, ar_hs, commit, wr_ok, rd_hit;
  logic [IdxBits-1:0]                wr_idx, rd_idx;
  logic                              unused_prot;

  assign unused_prot = ^{slv_req_i.aw.prot, slv_req_i.ar.prot};

  assign aw_hs  = slv_req_i.aw_valid & ~aw_full_q;
  assign w_hs   = slv_req_i.w_valid & ~w_full_q;
  assign ar_hs  = slv_req_i.ar_valid & ~r_valid_q;
  // A pending B that is being accepted this cycle frees the response slot for the next commit.
  assign commit = aw_full_q & w_full_q & (~b_valid_q | slv_req_i.b_ready);
  assign wr_idx = addr_idx(aw_addr_q);
  assign wr_ok  = addr_hit(aw_addr_q) & ~RoMask[wr_idx];
  assign rd_idx = addr_idx(slv_req_i.ar.addr);
  assign rd_hit = addr_hit(slv_req_i.ar.addr);

  // Next register state: hardware load beats a strobed bus write on the same register.
  always_comb begin
    regs_d = regs_q;
    for (int unsigned i = 0; i < NumRegs; i++) begin
      if (reg_load_i[i]) begin
        regs_d[i] = reg_d_i[i*DataWidth +: DataWidth];
      end else if (commit && wr_ok && (wr_idx == IdxBits'(i))) begin
        for (int unsigned b = 0; b < StrbWidth; b++) begin
          if (w_strb_q[b]) regs_d[i][8*b +: 8] = w_data_q[8*b +: 8];
        end
      end
    end
  end

  // Register bank.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) regs_q <= RegRstVal;
    else         regs_q <= regs_d;
  end

  // AW/W holding slots and B response.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      b_valid_q <= 1'b0;
      b_resp_q  <= RespOkay;
    end else begin
      if (aw_hs) begin
        aw_full_q <= 1'b1;
        aw_addr_q <= slv_req_i.aw.addr;
      end else if (commit) begin
        aw_full_q <= 1'b0;
      end
      if (w_hs) begin
        w_full_q <= 1'b1;
        w_data_q <= slv_req_i.w.data;
        w_strb_q <= slv_req_i.w.strb;
      end else if (commit) begin
        w_full_q <= 1'b0;
      end
      if (commit) begin
        b_valid_q <= 1'b1;
        b_resp_q  <= wr_ok ? RespOkay : RespSlvErr;
      end else if (slv_req_i.b_ready) begin
        b_valid_q <= 1'b0;
      end
    end
  end

  // Single-outstanding read; data is the register value before any same-edge write.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_resp_q  <= RespOkay;
    end else if (ar_hs) begin
      r_valid_q <= 1'b1;
      r_data_q  <= rd_hit ? regs_q[rd_idx] : '0;
      r_resp_q  <= rd_hit ? RespOkay : RespSlvErr;
    end else if (slv_req_i.r_ready) begin
      r_valid_q <= 1'b0;
    end
  end

  // Response struct and register export.
  always_comb begin
    slv_resp_o          = '0;
    slv_resp_o.aw_ready = ~aw_full_q;
    slv_resp_o.w_ready  = ~w_full_q;
    slv_resp_o.b.resp   = b_resp_q;
    slv_resp_o.b_valid  = b_valid_q;
    slv_resp_o.ar_ready = ~r_valid_q;
    slv_resp_o.r.data   = r_data_q;
    slv_resp_o.r.resp   = r_resp_q;
    slv_resp_o.r_valid  = r_valid_q;
  end

  assign reg_q_o = regs_q;

endmodule

// File: tb/tb_axi_lite_reg_responder.sv
// Scoreboard bench for axi_lite_reg_responder: expected B/R results are queued as
// requests are issued and popped when the responses come back.
module tb_axi_lite_reg_responder;
  import axi_lite_reg_responder_pkg::*;

  localparam logic [31:0]  Base   = 32'h0000_1000;
  localparam logic [15:0]  RoMask = 16'h0004;
  localparam logic [511:0] RstVal = (512'h33 << 96) | (512'hCAFE0002 << 64);
  localparam logic [1:0]   Okay   = 2'b00;
  localparam logic [1:0]   SlvErr = 2'b10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  req_t req;
  rsp_t rsp;
  logic               aw_valid, w_valid, b_ready, ar_valid, r_ready;
  logic [31:0]        aw_addr, w_data, ar_addr;
  logic [3:0]         w_strb;
  logic [15:0]        reg_load;
  logic [15:0][31:0]  reg_d, reg_q, model;

  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];
  int          vectors = 0;
  int          miscompares = 0;
  bit          hs_aw_ok, hs_w_ok;

  always_comb begin
    req          = '0;
    req.aw.addr  = aw_addr;
    req.aw_valid = aw_valid;
    req.w.data   = w_data;
    req.w.strb   = w_strb;
    req.w_valid  = w_valid;
    req.b_ready  = b_ready;
    req.ar.addr  = ar_addr;
    req.ar_valid = ar_valid;
    req.r_ready  = r_ready;
  end

  axi_lite_reg_responder #(
    .AddrWidth (32),
    .DataWidth (32),
    .NumRegs   (16),
    .BaseAddr  (Base),
    .RoMask    (RoMask),
    .RegRstVal (RstVal)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .slv_req_i  (req),
    .slv_resp_o (rsp),
    .reg_q_o    (reg_q),
    .reg_load_i (reg_load),
    .reg_d_i    (reg_d)
  );

  function automatic bit is_hit(input logic [31:0] addr);
    return (addr >= Base) && (((addr - Base) >> 2) < 32'd16);
  endfunction

  function automatic int idx_of(input logic [31:0] addr);
    return int'((addr - Base) >> 2);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] m;
    m = old;
    for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = d[8*b +: 8];
    return m;
  endfunction

  task automatic send_aw(input logic [31:0] addr, output bit ok);
    aw_addr = addr; aw_valid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (rsp.aw_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    aw_valid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb, output bit ok);
    w_data = data; w_strb = strb; w_valid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (rsp.w_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    w_valid = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] addr, output bit ok);
    ar_addr = addr; ar_valid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (rsp.ar_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    ar_valid = 1'b0;
  endtask

  task automatic recv_b(output logic [1:0] resp, output int waited);
    b_ready = 1'b1; waited = 0; resp = 'x;
    while (waited < 20) begin
      @(negedge clk);
      if (rsp.b_valid) begin
        resp = rsp.b.resp;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      waited++;
    end
    b_ready = 1'b0;
  endtask

  task automatic recv_r(output logic [33:0] got, output int waited);
    r_ready = 1'b1; waited = 0; got = 'x;
    while (waited < 20) begin
      @(negedge clk);
      if (rsp.r_valid) begin
        got = {rsp.r.data, rsp.r.resp};
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      waited++;
    end
    r_ready = 1'b0;
  endtask

  // AW and W presented in the same cycle; expectation queued and model updated.
  task automatic write_start(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
    fork
      send_aw(addr, hs_aw_ok);
      send_w(data, strb, hs_w_ok);
    join
    if (is_hit(addr) && !RoMask[idx_of(addr)]) begin
      exp_b.push_back(Okay);
      model[idx_of(addr)] = merge(model[idx_of(addr)], data, strb);
    end else begin
      exp_b.push_back(SlvErr);
    end
  endtask

  task automatic read_start(input logic [31:0] addr);
    bit ok;
    if (is_hit(addr)) exp_r.push_back({model[idx_of(addr)], Okay});
    else              exp_r.push_back({32'h0, SlvErr});
    send_ar(addr, ok);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    aw_valid = 0; w_valid = 0; b_ready = 0; ar_valid = 0; r_ready = 0;
    aw_addr = 0; w_data = 0; w_strb = 0; ar_addr = 0; reg_load = 0; reg_d = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    vectors++;
    if (rsp.aw_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_aw_ready: got %b want 1", rsp.aw_ready);
    end
    vectors++;
    if (rsp.w_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_w_ready: got %b want 1", rsp.w_ready);
    end
    vectors++;
    if (rsp.ar_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_ar_ready: got %b want 1", rsp.ar_ready);
    end
    vectors++;
    if ({rsp.b_valid, rsp.r_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_valids: got b=%b r=%b want 0 0", rsp.b_valid, rsp.r_valid);
    end
    vectors++;
    if ({rsp.b.resp, rsp.r.resp, rsp.r.data} !== 36'h0) begin
      miscompares++;
      $display("FAIL reset_resp: got b=%b r=%b data=%h want zero",
               rsp.b.resp, rsp.r.resp, rsp.r.data);
    end
    vectors++;
    if (reg_q !== RstVal) begin
      miscompares++; $display("FAIL reset_regs: got %h want %h", reg_q, RstVal);
    end
    model = RstVal;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read;
    logic [1:0]  resp;
    logic [33:0] got, e;
    int          waited;
    write_start(Base + 4, 32'hDEADBEEF, 4'b0101);
    vectors++;
    if ({hs_aw_ok, hs_w_ok} !== 2'b11) begin
      miscompares++; $display("FAIL wr_handshake: got %b want 11", {hs_aw_ok, hs_w_ok});
    end
    recv_b(resp, waited);
    vectors++;
    if (waited !== 1) begin
      miscompares++; $display("FAIL wr_b_latency: got %0d idle cycles want 1", waited);
    end
    e = {32'h0, exp_b.pop_front()};
    vectors++;
    if (resp !== e[1:0]) begin
      miscompares++; $display("FAIL wr_b_resp: got %b want %b", resp, e[1:0]);
    end
    vectors++;
    if (reg_q[1] !== 32'h00AD00EF) begin
      miscompares++; $display("FAIL wr_reg1: got %h want 00ad00ef", reg_q[1]);
    end
    read_start(Base + 4);
    recv_r(got, waited);
    vectors++;
    if (waited !== 0) begin
      miscompares++; $display("FAIL rd_latency: got %0d idle cycles want 0", waited);
    end
    e = exp_r.pop_front();
    vectors++;
    if (got !== e) begin
      miscompares++; $display("FAIL rd_reg1: got %h want %h", got, e);
    end
    // Full-word write, then a zero-strobe write that must leave the register alone.
    write_start(Base + 24, 32'h5A5A_C3C3, 4'b1111);
    recv_b(resp, waited);
    e[1:0] = exp_b.pop_front();
    write_start(Base + 24, 32'hFFFF_FFFF, 4'b0000);
    recv_b(resp, waited);
    e[1:0] = exp_b.pop_front();
    vectors++;
    if (resp !== e[1:0]) begin
      miscompares++; $display("FAIL wr_strb0_resp: got %b want %b", resp, e[1:0]);
    end
    read_start(Base + 24);
    recv_r(got, waited);
    e = exp_r.pop_front();
    vectors++;
    if (got !== e || got[33:2] !== 32'h5A5A_C3C3) begin
      miscompares++; $display("FAIL rd_reg6: got %h want %h", got, e);
    end
  endtask

  task automatic test_skew_backpressure;
    logic [1:0] resp, first;
    int         waited;
    bit         ok, bad, unstable, ok2a, ok2w;
    send_w(32'h1234_5678, 4'b1111, ok);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp.w_ready !== 1'b0) bad = 1'b1;
      @(posedge clk); #1;
    end
    vectors++;
    if (bad) begin
      miscompares++; $display("FAIL skew_w_ready: got w_ready=1 while W held want 0");
    end
    send_aw(Base + 16, ok);
    exp_b.push_back(Okay);
    model[4] = 32'h1234_5678;
    @(posedge clk); #1;
    unstable = 1'b0;
    first = rsp.b.resp;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          if (rsp.b_valid !== 1'b1 || rsp.b.resp !== first) unstable = 1'b1;
          @(posedge clk); #1;
        end
      end
      send_aw(Base + 20, ok2a);
      send_w(32'hA5A5_A5A5, 4'b1100, ok2w);
    join
    exp_b.push_back(Okay);
    model[5] = merge(model[5], 32'hA5A5_A5A5, 4'b1100);
    vectors++;
    if (unstable) begin
      miscompares++; $display("FAIL skew_b_stable: got B dropped or changed want held");
    end
    vectors++;
    if ({ok2a, ok2w} !== 2'b11) begin
      miscompares++; $display("FAIL skew_second_accept: got %b want 11", {ok2a, ok2w});
    end
    @(negedge clk);
    vectors++;
    if ({rsp.aw_ready, rsp.w_ready} !== 2'b00) begin
      miscompares++;
      $display("FAIL skew_slots_full: got %b want 00", {rsp.aw_ready, rsp.w_ready});
    end
    @(posedge clk); #1;
    recv_b(resp, waited);
    first = exp_b.pop_front();
    vectors++;
    if (resp !== first || waited !== 0) begin
      miscompares++; $display("FAIL skew_b1: got %b/%0d want %b/0", resp, waited, first);
    end
    recv_b(resp, waited);
    first = exp_b.pop_front();
    vectors++;
    if (resp !== first || waited !== 0) begin
      miscompares++; $display("FAIL skew_b2_b2b: got %b/%0d want %b/0", resp, waited, first);
    end
    vectors++;
    if (reg_q !== model) begin
      miscompares++; $display("FAIL skew_regs: got %h want %h", reg_q, model);
    end
  endtask

  task automatic test_errors;
    logic [1:0]  resp, e;
    logic [33:0] got, er;
    int          waited;
    write_start(Base + 64, 32'hFFFF_FFFF, 4'b1111);
    recv_b(resp, waited);
    e = exp_b.pop_front();
    vectors++;
    if (resp !== e || resp !== SlvErr) begin
      miscompares++; $display("FAIL err_wr_oob: got %b want %b", resp, e);
    end
    write_start(Base + 8, 32'h0BAD_0BAD, 4'b1111);
    recv_b(resp, waited);
    e = exp_b.pop_front();
    vectors++;
    if (resp !== e) begin
      miscompares++; $display("FAIL err_wr_ro: got %b want %b", resp, e);
    end
    write_start(Base - 4, 32'h1111_1111, 4'b1111);
    recv_b(resp, waited);
    e = exp_b.pop_front();
    vectors++;
    if (resp !== e) begin
      miscompares++; $display("FAIL err_wr_below: got %b want %b", resp, e);
    end
    vectors++;
    if (reg_q !== model) begin
      miscompares++; $display("FAIL err_regs: got %h want %h", reg_q, model);
    end
    read_start(Base + 64);
    recv_r(got, waited);
    er = exp_r.pop_front();
    vectors++;
    if (got !== er) begin
      miscompares++; $display("FAIL err_rd_oob: got %h want %h", got, er);
    end
    read_start(Base + 8);
    recv_r(got, waited);
    er = exp_r.pop_front();
    vectors++;
    if (got !== er) begin
      miscompares++; $display("FAIL rd_ro_reg: got %h want %h", got, er);
    end
  endtask

  task automatic test_collision;
    logic [1:0]  resp, e;
    logic [33:0] got, er;
    int          waited;
    logic [31:0] old3;
    old3 = model[3];
    write_start(Base + 12, 32'h0000_0001, 4'b1111);
    // Commit, hardware loads and AR all land on the next edge.
    exp_r.push_back({old3, Okay});
    ar_addr = Base + 12; ar_valid = 1'b1;
    reg_load = 16'h000C; reg_d[3] = 32'h5; reg_d[2] = 32'h77;
    @(posedge clk); #1;
    ar_valid = 1'b0; reg_load = '0;
    model[3] = 32'h5;
    model[2] = 32'h77;
    recv_b(resp, waited);
    e = exp_b.pop_front();
    vectors++;
    if (resp !== e) begin
      miscompares++; $display("FAIL coll_b: got %b want %b", resp, e);
    end
    recv_r(got, waited);
    er = exp_r.pop_front();
    vectors++;
    if (got !== er) begin
      miscompares++; $display("FAIL coll_rd_old: got %h want %h", got, er);
    end
    vectors++;
    if (reg_q !== model) begin
      miscompares++; $display("FAIL coll_regs: got %h want %h", reg_q, model);
    end
  endtask

  task automatic test_reset_midop;
    bit bad;
    write_start(Base, 32'h1111_1111, 4'b1111);
    ar_addr = Base; ar_valid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if ({rsp.b_valid, rsp.r_valid} !== 2'b11) begin
      miscompares++;
      $display("FAIL midop_pending: got b=%b r=%b want 1 1", rsp.b_valid, rsp.r_valid);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    ar_valid = 1'b0;
    rst_n = 1'b1;
    exp_b.delete();
    exp_r.delete();
    model = RstVal;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp.b_valid || rsp.r_valid || !rsp.aw_ready || !rsp.w_ready || !rsp.ar_ready)
        bad = 1'b1;
      @(posedge clk); #1;
    end
    vectors++;
    if (bad) begin
      miscompares++; $display("FAIL midop_after_reset: got stale response or low ready");
    end
    vectors++;
    if (reg_q !== model) begin
      miscompares++; $display("FAIL midop_regs: got %h want %h", reg_q, model);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_read();
    test_skew_backpressure();
    test_errors();
    test_collision();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
